// File: rtl/alu_exec_unit.sv
// RV32I execute-stage ALU: opcode/funct decode, 32-bit datapath and one output register stage.
// Define ALU_BRANCH_EN to build the branch comparator; otherwise Branch_Enable is tied low.
module alu_exec_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  FuncCode,
    input  logic [6:0]  Opcode,
    output logic [31:0] ALUOut,
    output logic        Branch_Enable
);

    typedef enum logic [6:0] {
        OP_ZERO, OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
        OP_OR, OP_AND, OP_PASSB,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_BNEVER
    } alu_op_e;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    function automatic alu_op_e rtype_op(input logic [3:0] fc);
        case (fc)
            4'b0000: return OP_ADD;
            4'b1000: return OP_SUB;
            4'b0001: return OP_SLL;
            4'b0010: return OP_SLT;
            4'b0011: return OP_SLTU;
            4'b0100: return OP_XOR;
            4'b0101: return OP_SRL;
            4'b1101: return OP_SRA;
            4'b0110: return OP_OR;
            4'b0111: return OP_AND;
            default: return OP_ZERO;
        endcase
    endfunction

    alu_op_e     alu_op;
    logic [31:0] alu_result;

    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        alu_op = OP_ZERO;
        case (Opcode)
            OPC_RTYPE: alu_op = rtype_op(FuncCode);
            // Immediate forms only honour funct7[5] for the shift-right pair.
            OPC_ITYPE: alu_op = (FuncCode[2:0] == 3'b101) ? rtype_op(FuncCode)
                                                          : rtype_op({1'b0, FuncCode[2:0]});
            OPC_LOAD, OPC_STORE, OPC_AUIPC, OPC_JAL, OPC_JALR: alu_op = OP_ADD;
            OPC_LUI:   alu_op = OP_PASSB;
            OPC_BRANCH: begin
                case (FuncCode[2:0])
                    3'b000:  alu_op = OP_BEQ;
                    3'b001:  alu_op = OP_BNE;
                    3'b100:  alu_op = OP_BLT;
                    3'b101:  alu_op = OP_BGE;
                    3'b110:  alu_op = OP_BLTU;
                    3'b111:  alu_op = OP_BGEU;
                    default: alu_op = OP_BNEVER;
                endcase
            end
            default:   alu_op = OP_ZERO;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (alu_op)
            OP_ADD:   alu_result = A + B;
            OP_SUB:   alu_result = A - B;
            OP_SLL:   alu_result = A << B[4:0];
            OP_SLT:   alu_result = {31'd0, $signed(A) < $signed(B)};
            OP_SLTU:  alu_result = {31'd0, A < B};
            OP_XOR:   alu_result = A ^ B;
            OP_SRL:   alu_result = A >> B[4:0];
            OP_SRA:   alu_result = $signed(A) >>> B[4:0];
            OP_OR:    alu_result = A | B;
            OP_AND:   alu_result = A & B;
            OP_PASSB: alu_result = B;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_BNEVER:
                      alu_result = A - B;
            default:  alu_result = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ALUOut <= '0;
        else        ALUOut <= alu_result;
    end

`ifdef ALU_BRANCH_EN
    logic branch_taken;

    always_comb begin
        branch_taken = 1'b0;
        case (alu_op)
            OP_BEQ:  branch_taken = (A == B);
            OP_BNE:  branch_taken = (A != B);
            OP_BLT:  branch_taken = ($signed(A) <  $signed(B));
            OP_BGE:  branch_taken = ($signed(A) >= $signed(B));
            OP_BLTU: branch_taken = (A <  B);
            OP_BGEU: branch_taken = (A >= B);
            default: branch_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) Branch_Enable <= 1'b0;
        else        Branch_Enable <= branch_taken;
    end
`else
    assign Branch_Enable = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vectors, reset behaviour, and random
// operations compared against an arithmetic reference model.
module tb_alu_exec_unit;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

`ifdef ALU_BRANCH_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] A, B;
    logic [3:0]  FuncCode;
    logic [6:0]  Opcode;
    logic [31:0] ALUOut;
    logic        Branch_Enable;

    int total = 0;
    int bad   = 0;

    alu_exec_unit dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .FuncCode(FuncCode),
        .Opcode(Opcode), .ALUOut(ALUOut), .Branch_Enable(Branch_Enable)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got br=%0b out=%h, expected br=%0b out=%h",
                     tag, got[32], got[31:0], exp[32], exp[31:0]);
        end
    endtask

    // Register-register semantics written directly from the instruction definitions.
    function automatic logic [31:0] rtype_ref(input logic [3:0] fc, input logic [31:0] a,
                                              input logic [31:0] b);
        int unsigned sh = b % 32;
        case (fc)
            4'b0000: return a + b;
            4'b1000: return a + (~b + 32'd1);
            4'b0001: return a * (32'd1 << sh);
            4'b0010: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return a / (32'd1 << sh);
            4'b1101: return a[31] ? ~((~a) >> sh) : (a >> sh);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [32:0] ref_model(input logic [6:0] op, input logic [3:0] fc,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r = 32'd0;
        logic        t = 1'b0;
        case (op)
            OPC_RTYPE: r = rtype_ref(fc, a, b);
            OPC_ITYPE: r = rtype_ref((fc[2:0] == 3'b101) ? fc : {1'b0, fc[2:0]}, a, b);
            7'b0000011, 7'b0100011, 7'b0010111, 7'b1101111, 7'b1100111: r = a + b;
            OPC_LUI:   r = b;
            OPC_BRANCH: begin
                r = a - b;
                case (fc[2:0])
                    3'b000: t = (a == b);
                    3'b001: t = (a != b);
                    3'b100: t = (int'(a) <  int'(b));
                    3'b101: t = (int'(a) >= int'(b));
                    3'b110: t = (a <  b);
                    3'b111: t = (a >= b);
                    default: t = 1'b0;
                endcase
                t = t & BR_EN;
            end
            default: r = 32'd0;
        endcase
        return {t, r};
    endfunction

    task automatic drive(input logic [6:0] op, input logic [3:0] fc,
                         input logic [31:0] a, input logic [31:0] b);
        Opcode = op; FuncCode = fc; A = a; B = b;
    endtask

    // Drive one operation and check it one cycle later against literal expectations.
    task automatic run(input string tag, input logic [6:0] op, input logic [3:0] fc,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_out, input logic exp_br);
        drive(op, fc, a, b);
        @(posedge clk); #1;
        check(tag, {Branch_Enable, ALUOut}, {exp_br & BR_EN, exp_out});
    endtask

    logic [6:0] opc_pool [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0010111,
                                  7'b1101111, 7'b1100111, 7'b0110111, 7'b1100011, 7'b1100011,
                                  7'b0000000};

    initial begin
        rst_n = 1'b0;
        drive(OPC_RTYPE, 4'b0000, 32'd1, 32'd2);
        repeat (2) @(posedge clk);
        #1 check("reset_hold", {Branch_Enable, ALUOut}, 33'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_after_reset", {Branch_Enable, ALUOut}, {1'b0, 32'd3});

        run("and",  OPC_RTYPE, 4'b0111, 32'h0F, 32'h55, 32'h05, 1'b0);
        run("or",   OPC_RTYPE, 4'b0110, 32'h0F, 32'h55, 32'h5F, 1'b0);
        run("xor",  OPC_RTYPE, 4'b0100, 32'h55, 32'hFF, 32'hAA, 1'b0);
        run("add",  OPC_RTYPE, 4'b0000, 32'd10000, 32'd111, 32'd10111, 1'b0);
        run("sub",  OPC_RTYPE, 4'b1000, 32'd10000, 32'd111, 32'd9889, 1'b0);
        run("slt",  OPC_RTYPE, 4'b0010, 32'd0, 32'd2, 32'd1, 1'b0);
        run("slt_neg",  OPC_RTYPE, 4'b0010, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
        run("sltu_big", OPC_RTYPE, 4'b0011, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
        run("srl",  OPC_RTYPE, 4'b0101, 32'd16, 32'd2, 32'd4, 1'b0);
        run("sra",  OPC_RTYPE, 4'b1101, 32'd8, 32'd1, 32'd4, 1'b0);
        run("sra_neg", OPC_RTYPE, 4'b1101, 32'h80000000, 32'd4, 32'hF8000000, 1'b0);
        run("sll_mask", OPC_RTYPE, 4'b0001, 32'd2, 32'h22, 32'd8, 1'b0);
        run("r_undef",  OPC_RTYPE, 4'b1111, 32'd7, 32'd9, 32'd0, 1'b0);
        run("beq",  OPC_BRANCH, 4'b0000, 32'd5, 32'd5, 32'd0, 1'b1);
        run("bne",  OPC_BRANCH, 4'b0001, 32'd5, 32'd5, 32'd0, 1'b0);
        run("blt",  OPC_BRANCH, 4'b0100, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 1'b1);
        run("bltu", OPC_BRANCH, 4'b0110, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 1'b0);
        run("b010", OPC_BRANCH, 4'b0010, 32'd3, 32'd3, 32'd0, 1'b0);
        run("addi", OPC_ITYPE, 4'b1000, 32'd5, 32'd3, 32'd8, 1'b0);
        run("srai", OPC_ITYPE, 4'b1101, 32'h80000000, 32'd1, 32'hC0000000, 1'b0);
        run("lui",  OPC_LUI, 4'b0000, 32'hDEAD, 32'h12345000, 32'h12345000, 1'b0);
        run("jalr", 7'b1100111, 4'b1000, 32'd100, 32'd4, 32'd104, 1'b0);
        run("unknown", 7'b1111111, 4'b0000, 32'd5, 32'd5, 32'd0, 1'b0);

        // Asynchronous reset between edges, then recovery on the next edge.
        run("pre_reset_add", OPC_RTYPE, 4'b0000, 32'd7, 32'd9, 32'd16, 1'b0);
        @(negedge clk) rst_n = 1'b0;
        #1 check("async_reset", {Branch_Enable, ALUOut}, 33'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset", {Branch_Enable, ALUOut}, {1'b0, 32'd16});

        for (int i = 0; i < 400; i++) begin
            logic [6:0]  op;
            logic [3:0]  fc;
            logic [31:0] a, b;
            op = opc_pool[$urandom_range(0, 10)];
            if (op == 7'b0000000) op = 7'($urandom);
            fc = 4'($urandom);
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = 32'($urandom_range(0, 40));
                default: b = $urandom;
            endcase
            drive(op, fc, a, b);
            @(posedge clk); #1;
            check($sformatf("rand%0d_op%b_fc%b", i, op, fc),
                  {Branch_Enable, ALUOut}, ref_model(op, fc, a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
